// File: rtl/puf_pkg.sv
// Shared definitions for the RO PUF challenge side: state encoding, challenge
// layout and sizing constants used by the sequencer, the PUF top and the bench.
package puf_pkg;

    localparam int unsigned CHAL_W       = 10;
    localparam int unsigned RO_IDX_W     = 4;
    localparam int unsigned CFG_W        = 6;
    localparam int unsigned MAX_RO_IDX   = 8;
    localparam int unsigned CLEAR_CYCLES = 2;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_DONE    = 3'd5
    } puf_state_e;

    // Challenge word presented to the PUF: RO select on top, configuration below.
    typedef struct packed {
        logic [RO_IDX_W-1:0] ro_idx;
        logic [CFG_W-1:0]    cfg;
    } puf_chal_t;

    // Configuration for bit k; the sum wraps naturally at 2**CFG_W.
    function automatic logic [CFG_W-1:0] cfg_for_bit(input logic [CFG_W-1:0] base,
                                                     input logic [CFG_W-1:0] k);
        return base + k;
    endfunction

endpackage

// File: rtl/puf_watchdog.sv
// Run-phase watchdog: counts enabled cycles and flags once TIMEOUT is reached.
module puf_watchdog
#(
    parameter int unsigned TIMEOUT = 600_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter stops once expired so the flag stays up until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_response_sequencer.sv
// Challenge-side controller for the RO PUF: measures an A/B ring pair per bit
// and builds a RESP_BITS-wide response from the count comparisons.
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int unsigned RESP_BITS = 8,
    parameter int unsigned COUNT_W   = 32,
    parameter int unsigned TIMEOUT   = 600_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [RO_IDX_W-1:0]  ro_a,
    input  logic [RO_IDX_W-1:0]  ro_b,
    input  logic [CFG_W-1:0]     cfg_base,
    output logic [CHAL_W-1:0]    puf_challenge,
    output logic                 puf_en,
    input  logic [COUNT_W-1:0]   puf_count,
    input  logic                 puf_completed,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RESP_BITS-1:0] response
);

    localparam int unsigned K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(RESP_BITS - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    localparam logic [STATE_W-1:0] S_IDLE    = ST_IDLE;
    localparam logic [STATE_W-1:0] S_CLEAR   = ST_CLEAR;
    localparam logic [STATE_W-1:0] S_RUN     = ST_RUN;
    localparam logic [STATE_W-1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [STATE_W-1:0] S_DECIDE  = ST_DECIDE;
    localparam logic [STATE_W-1:0] S_DONE    = ST_DONE;

    logic [STATE_W-1:0]   state_q, state_n;
    logic                 phase_q, phase_n;
    logic [K_W-1:0]       k_q, k_n;
    logic [CLR_W-1:0]     clr_q, clr_n;
    logic [RO_IDX_W-1:0]  ro_a_q, ro_a_n;
    logic [RO_IDX_W-1:0]  ro_b_q, ro_b_n;
    logic [CFG_W-1:0]     cfg_q, cfg_n;
    logic [COUNT_W-1:0]   cnt_a_q, cnt_a_n;
    logic [COUNT_W-1:0]   cnt_b_q, cnt_b_n;
    logic [RESP_BITS-1:0] resp_n;
    logic                 err_n;
    logic [CHAL_W-1:0]    chal_n;
    puf_chal_t            chal_c;

    logic params_bad_c;
    logic wd_clear_c;
    logic wd_en_c;
    logic wd_expired;

    assign params_bad_c = (ro_a > RO_IDX_W'(MAX_RO_IDX)) ||
                          (ro_b > RO_IDX_W'(MAX_RO_IDX)) ||
                          (ro_a == ro_b);

    assign wd_en_c    = (state_q == S_RUN);
    assign wd_clear_c = (state_q != S_RUN);

    puf_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_c),
        .en      (wd_en_c),
        .expired (wd_expired)
    );

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        k_n     = k_q;
        clr_n   = clr_q;
        ro_a_n  = ro_a_q;
        ro_b_n  = ro_b_q;
        cfg_n   = cfg_q;
        cnt_a_n = cnt_a_q;
        cnt_b_n = cnt_b_q;
        resp_n  = response;
        err_n   = err;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ro_a_n  = ro_a;
                    ro_b_n  = ro_b;
                    cfg_n   = cfg_base;
                    resp_n  = '0;
                    err_n   = 1'b0;
                    k_n     = '0;
                    phase_n = 1'b0;
                    clr_n   = '0;
                    if (params_bad_c) begin
                        err_n   = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_n = S_RUN;
                end else begin
                    clr_n = clr_q + CLR_W'(1);
                end
            end
            S_RUN: begin
                // A completion in the same cycle as expiry still counts.
                if (puf_completed) begin
                    state_n = S_CAPTURE;
                end else if (wd_expired) begin
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_CAPTURE: begin
                clr_n = '0;
                if (!phase_q) begin
                    cnt_a_n = puf_count;
                    phase_n = 1'b1;
                    state_n = S_CLEAR;
                end else begin
                    cnt_b_n = puf_count;
                    state_n = S_DECIDE;
                end
            end
            S_DECIDE: begin
                resp_n[k_q] = (cnt_a_q > cnt_b_q);
                if (k_q == K_LAST) begin
                    state_n = S_DONE;
                end else begin
                    k_n     = k_q + K_W'(1);
                    phase_n = 1'b0;
                    clr_n   = '0;
                    state_n = S_CLEAR;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Challenge is loaded on entry to CLEAR and held through CAPTURE.
        chal_c.ro_idx = phase_n ? ro_b_n : ro_a_n;
        chal_c.cfg    = cfg_for_bit(cfg_n, CFG_W'(k_n));
        chal_n        = (state_n == S_CLEAR) ? chal_c : puf_challenge;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            k_q           <= '0;
            clr_q         <= '0;
            ro_a_q        <= '0;
            ro_b_q        <= '0;
            cfg_q         <= '0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            response      <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            puf_en        <= 1'b0;
            puf_challenge <= '0;
        end else begin
            state_q       <= state_n;
            phase_q       <= phase_n;
            k_q           <= k_n;
            clr_q         <= clr_n;
            ro_a_q        <= ro_a_n;
            ro_b_q        <= ro_b_n;
            cfg_q         <= cfg_n;
            cnt_a_q       <= cnt_a_n;
            cnt_b_q       <= cnt_b_n;
            response      <= resp_n;
            err           <= err_n;
            done          <= (state_q == S_DONE);
            busy          <= (state_n != S_IDLE);
            puf_en        <= (state_n == S_RUN);
            puf_challenge <= chal_n;
        end
    end

endmodule
